// File: rtl/arm7_reg_bank_pkg.sv
// Shared definitions for the ARM7 register bank: compact mode encoding, CPSR mode
// patterns and CPSR bit positions, plus the 5-bit to 3-bit mode decode.
package arm7_pkg;

    localparam logic [2:0] MODE_USR = 3'd0;
    localparam logic [2:0] MODE_SYS = 3'd1;
    localparam logic [2:0] MODE_FIQ = 3'd2;
    localparam logic [2:0] MODE_IRQ = 3'd3;
    localparam logic [2:0] MODE_SVC = 3'd4;
    localparam logic [2:0] MODE_ABT = 3'd5;
    localparam logic [2:0] MODE_UND = 3'd6;

    localparam logic [4:0] CPSR_USR = 5'b10000;
    localparam logic [4:0] CPSR_SYS = 5'b11111;
    localparam logic [4:0] CPSR_FIQ = 5'b10001;
    localparam logic [4:0] CPSR_IRQ = 5'b10010;
    localparam logic [4:0] CPSR_SVC = 5'b10011;
    localparam logic [4:0] CPSR_ABT = 5'b10111;
    localparam logic [4:0] CPSR_UND = 5'b11011;

    localparam int CPSR_N_BIT    = 31;
    localparam int CPSR_Z_BIT    = 30;
    localparam int CPSR_C_BIT    = 29;
    localparam int CPSR_V_BIT    = 28;
    localparam int CPSR_I_BIT    = 7;
    localparam int CPSR_F_BIT    = 6;
    localparam int CPSR_MODE_MSB = 4;
    localparam int CPSR_MODE_LSB = 0;

    // Unrecognised mode patterns fall back to the user register view.
    function automatic logic [2:0] mode5_to_mode3(input logic [4:0] mode5);
        case (mode5)
            CPSR_USR: return MODE_USR;
            CPSR_SYS: return MODE_SYS;
            CPSR_FIQ: return MODE_FIQ;
            CPSR_IRQ: return MODE_IRQ;
            CPSR_SVC: return MODE_SVC;
            CPSR_ABT: return MODE_ABT;
            CPSR_UND: return MODE_UND;
            default:  return MODE_USR;
        endcase
    endfunction

endpackage

// File: rtl/arm7_reg_bank_if.sv
// Request/response bundle between the execute unit (master) and the register bank (slave).
interface arm7_reg_bank_if;
    // Every *_en is a one-cycle pulse sampled at a rising edge; the matching *_read_value
    // is loaded at that same edge and held until the next request on that port. There is
    // no ready/stall: the bank accepts every pulse, and writes commit at the sampling edge.
    logic        read_en;
    logic [3:0]  read_reg;
    logic [31:0] read_value;
    logic        write_en;
    logic [3:0]  write_reg;
    logic [31:0] write_value;
    logic        write_restore_from_SPSR;
    logic        mode_read_en;
    logic [31:0] mode_read_value;
    logic        cpsr_read_en;
    logic [31:0] cpsr_read_value;
    logic        cpsr_write_en;
    logic [31:0] cpsr_write_value;
    logic        spsr_read_en;
    logic [31:0] spsr_read_value;
    logic        spsr_write_en;
    logic [31:0] spsr_write_value;
    logic [31:0] pc_value;

    modport master (
        output read_en, read_reg, write_en, write_reg, write_value, write_restore_from_SPSR,
        output mode_read_en, cpsr_read_en, cpsr_write_en, cpsr_write_value,
        output spsr_read_en, spsr_write_en, spsr_write_value,
        input  read_value, mode_read_value, cpsr_read_value, spsr_read_value, pc_value
    );

    modport slave (
        input  read_en, read_reg, write_en, write_reg, write_value, write_restore_from_SPSR,
        input  mode_read_en, cpsr_read_en, cpsr_write_en, cpsr_write_value,
        input  spsr_read_en, spsr_write_en, spsr_write_value,
        output read_value, mode_read_value, cpsr_read_value, spsr_read_value, pc_value
    );
endinterface

// File: rtl/arm7_reg_bank_index.sv
// Maps (mode, architectural register) onto the 31-entry physical register file:
// 0-15 user set, 16-22 FIQ r8-r14, then r13/r14 pairs for IRQ, SVC, ABT, UND.
module arm7_bank_index
    import arm7_pkg::*;
(
    input  logic [2:0] mode3,
    input  logic [3:0] reg4,
    output logic [4:0] phys_idx
);

    always_comb begin
        phys_idx = {1'b0, reg4};
        case (mode3)
            MODE_FIQ: if (reg4 >= 4'd8 && reg4 <= 4'd14) phys_idx = 5'd8 + {1'b0, reg4};
            MODE_IRQ: if (reg4 == 4'd13 || reg4 == 4'd14) phys_idx = 5'd10 + {1'b0, reg4};
            MODE_SVC: if (reg4 == 4'd13 || reg4 == 4'd14) phys_idx = 5'd12 + {1'b0, reg4};
            MODE_ABT: if (reg4 == 4'd13 || reg4 == 4'd14) phys_idx = 5'd14 + {1'b0, reg4};
            MODE_UND: if (reg4 == 4'd13 || reg4 == 4'd14) phys_idx = 5'd16 + {1'b0, reg4};
            default:  phys_idx = {1'b0, reg4};
        endcase
    end

endmodule

// File: rtl/arm7_reg_bank.sv
// Banked ARM7 GPR file, CPSR and per-mode SPSRs; sole owner of architectural state
// and responder for the execute unit's register/mode/status request interface.
module arm7_reg_bank
    import arm7_pkg::*;
#(
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    arm7_reg_bank_if.slave     bus
);

    logic [31:0] gpr [31];
    logic [31:0] cpsr;
    logic [31:0] spsr [5];

    logic [2:0]  mode3;
    logic        has_spsr;
    logic [2:0]  spsr_sel;
    logic [31:0] spsr_cur;
    logic [4:0]  rd_idx;
    logic [4:0]  wr_idx;
    logic        restore;

    assign mode3    = mode5_to_mode3(cpsr[CPSR_MODE_MSB:CPSR_MODE_LSB]);
    assign has_spsr = (mode3 >= MODE_FIQ);
    assign spsr_sel = mode3 - MODE_FIQ;
    assign spsr_cur = has_spsr ? spsr[spsr_sel] : 32'h0;
    assign restore  = bus.write_en && (bus.write_reg == 4'd15) &&
                      bus.write_restore_from_SPSR && has_spsr;

    assign bus.pc_value = gpr[15];

    arm7_bank_index u_rd_index (.mode3(mode3), .reg4(bus.read_reg),  .phys_idx(rd_idx));
    arm7_bank_index u_wr_index (.mode3(mode3), .reg4(bus.write_reg), .phys_idx(wr_idx));

    // Reads capture pre-edge contents, so a same-edge write is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 31; i++) gpr[i] <= 32'h0;
            gpr[15] <= RESET_PC;
            cpsr    <= RESET_CPSR;
            for (int i = 0; i < 5; i++) spsr[i] <= 32'h0;
            bus.read_value      <= 32'h0;
            bus.mode_read_value <= 32'h0;
            bus.cpsr_read_value <= 32'h0;
            bus.spsr_read_value <= 32'h0;
        end else begin
            if (bus.read_en)      bus.read_value      <= gpr[rd_idx];
            if (bus.mode_read_en) bus.mode_read_value <= {29'b0, mode3};
            if (bus.cpsr_read_en) bus.cpsr_read_value <= cpsr;
            if (bus.spsr_read_en) bus.spsr_read_value <= spsr_cur;

            if (bus.write_en) gpr[wr_idx] <= bus.write_value;

            // Exception return outranks an explicit CPSR write in the same cycle.
            if (restore)                cpsr <= spsr_cur;
            else if (bus.cpsr_write_en) cpsr <= bus.cpsr_write_value;

            if (bus.spsr_write_en && has_spsr) spsr[spsr_sel] <= bus.spsr_write_value;
        end
    end

endmodule
